z_to_z_stream_unit: RTL and testbench

- Parametrised successor to the z-to-z derivative stage in the backprop stack.
- Latches an activation-derivative vector and multiplies it lane-wise by each incoming dense-derivative row, optionally scaled by a cost-derivative row (output layer).
- Uses signed fixed-point arithmetic with rounding and saturation.
- Emits results diagonally skewed (lane c delayed c cycles) for direct feed into the systolic array, with per-lane valid and row/layer tagging.

---
 rtl/z_to_z_stream_unit.sv | 177 +++++++++++++++++
 tb/tb_z_to_z_stream_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_to_z_stream_unit.sv
// Lane-wise fixed-point product of activation and dense derivatives, optionally
// scaled by a cost row, emitted diagonally skewed for the systolic array.
module z_to_z_stream_unit #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int SIZE      = 3,
  parameter int ROWS      = 3,
  parameter int CNT_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      set_diff_act,
  input  logic [DATA_SIZE*SIZE-1:0] diff_act,
  input  logic [DATA_SIZE*SIZE-1:0] diff_dense,
  input  logic [DATA_SIZE*SIZE-1:0] diff_cost,
  input  logic                      use_cost,
  input  logic                      start_new_layer,
  output logic [DATA_SIZE*SIZE-1:0] diff_z_to_z,
  output logic [SIZE-1:0]           out_valid,
  output logic [CNT_W-1:0]          row_idx,
  output logic                      layer_done,
  output logic                      sat_flag
);

  localparam int PW = 2*DATA_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC_BITS - 1);

  typedef logic signed [DATA_SIZE-1:0] lane_t;

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] prod);
    return (prod + HALF) >>> FRAC_BITS;
  endfunction

  // Returns {clamped, value}; in range when all bits above the sign bit agree.
  function automatic logic [DATA_SIZE:0] saturate(input logic signed [PW-1:0] v);
    if (v[PW-1:DATA_SIZE-1] == {(PW-DATA_SIZE+1){v[PW-1]}})
      return {1'b0, v[DATA_SIZE-1:0]};
    else if (v[PW-1])
      return {1'b1, 1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DATA_SIZE-1){1'b1}}};
  endfunction

  function automatic logic [DATA_SIZE:0] fmul(input lane_t a, input lane_t b);
    return saturate(round_shift(PW'(a) * PW'(b)));
  endfunction

  lane_t                act_q    [SIZE];
  lane_t                act_in   [SIZE];
  lane_t                dense_in [SIZE];
  lane_t                cost_in  [SIZE];
  logic [DATA_SIZE:0]   m_p0     [SIZE];
  lane_t                p_next   [SIZE];
  logic                 sat_p0;
  lane_t                p_p1     [SIZE];
  lane_t                cost_p1  [SIZE];
  logic                 vld_p1, use_cost_p1, last_p1;
  logic [DATA_SIZE:0]   m_p1     [SIZE];
  lane_t                r_next   [SIZE];
  logic                 sat_p1;
  lane_t                r_p2     [SIZE];
  logic                 vld_p2, last_p2;
  lane_t                lane_d   [SIZE];
  logic [SIZE-1:0]      lane_v;
  logic                 last_out;
  logic [CNT_W-1:0]     row_cnt;

  assign row_idx = start_new_layer ? '0 : row_cnt;

  // Stage p0: unpack lanes, bypass a freshly loaded activation, first multiply
  always_comb begin
    sat_p0 = 1'b0;
    for (int c = 0; c < SIZE; c++) begin
      act_in[c]   = diff_act[DATA_SIZE*(SIZE-c)-1 -: DATA_SIZE];
      dense_in[c] = diff_dense[DATA_SIZE*(SIZE-c)-1 -: DATA_SIZE];
      cost_in[c]  = diff_cost[DATA_SIZE*(SIZE-c)-1 -: DATA_SIZE];
      m_p0[c]     = fmul(set_diff_act ? act_in[c] : act_q[c], dense_in[c]);
      p_next[c]   = m_p0[c][DATA_SIZE-1:0];
      sat_p0      = sat_p0 | (in_valid & m_p0[c][DATA_SIZE]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q       <= '{default: '0};
      p_p1        <= '{default: '0};
      cost_p1     <= '{default: '0};
      vld_p1      <= 1'b0;
      use_cost_p1 <= 1'b0;
      last_p1     <= 1'b0;
      row_cnt     <= '0;
    end else begin
      if (set_diff_act) act_q <= act_in;
      p_p1        <= p_next;
      cost_p1     <= cost_in;
      vld_p1      <= in_valid;
      use_cost_p1 <= use_cost;
      last_p1     <= in_valid && (row_idx == LAST_ROW);
      if (in_valid)
        row_cnt <= (row_idx == LAST_ROW) ? '0 : row_idx + CNT_W'(1);
      else if (start_new_layer)
        row_cnt <= '0;
    end
  end

  // Stage p1: optional cost scaling
  always_comb begin
    sat_p1 = 1'b0;
    for (int c = 0; c < SIZE; c++) begin
      m_p1[c]   = fmul(p_p1[c], cost_p1[c]);
      r_next[c] = use_cost_p1 ? m_p1[c][DATA_SIZE-1:0] : p_p1[c];
      sat_p1    = sat_p1 | (vld_p1 & use_cost_p1 & m_p1[c][DATA_SIZE]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p2     <= '{default: '0};
      vld_p2   <= 1'b0;
      last_p2  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      r_p2     <= r_next;
      vld_p2   <= vld_p1;
      last_p2  <= last_p1;
      sat_flag <= (sat_flag & ~start_new_layer) | sat_p0 | sat_p1;
    end
  end

  // Stage p2: lane c waits c extra cycles; bubbles read as zero
  for (genvar c = 0; c < SIZE; c++) begin : g_lane
    if (c == 0) begin : g_direct
      assign lane_d[c] = r_p2[c];
      assign lane_v[c] = vld_p2;
    end else begin : g_dly
      lane_t        d [c];
      logic [c-1:0] v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d <= '{default: '0};
          v <= '0;
        end else begin
          d[0] <= r_p2[c];
          v[0] <= vld_p2;
          for (int k = 1; k < c; k++) begin
            d[k] <= d[k-1];
            v[k] <= v[k-1];
          end
        end
      end
      assign lane_d[c] = d[c-1];
      assign lane_v[c] = v[c-1];
    end
    assign diff_z_to_z[DATA_SIZE*(SIZE-c)-1 -: DATA_SIZE] = lane_v[c] ? lane_d[c] : '0;
  end

  if (SIZE > 1) begin : g_last_dly
    logic [SIZE-2:0] last_sk;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_sk <= '0;
      end else begin
        last_sk[0] <= last_p2;
        for (int k = 1; k < SIZE-1; k++) last_sk[k] <= last_sk[k-1];
      end
    end
    assign last_out = last_sk[SIZE-2];
  end else begin : g_last_direct
    assign last_out = last_p2;
  end

  assign out_valid  = lane_v;
  assign layer_done = lane_v[SIZE-1] & last_out;

endmodule

// File: tb/tb_z_to_z_stream_unit.sv
// Bench for z_to_z_stream_unit: directed rows, per-cycle comparison against a
// cycle-indexed expectation table built from the arithmetic rules.
module tb_z_to_z_stream_unit;
  localparam int DW = 16, FB = 8, S = 3, NR = 3, CW = 2, DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, set_diff_act, use_cost, start_new_layer;
  logic [DW*S-1:0] diff_act, diff_dense, diff_cost, diff_z_to_z;
  logic [S-1:0]    out_valid;
  logic [CW-1:0]   row_idx;
  logic            layer_done, sat_flag;

  z_to_z_stream_unit #(.DATA_SIZE(DW), .FRAC_BITS(FB), .SIZE(S), .ROWS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .set_diff_act(set_diff_act),
    .diff_act(diff_act), .diff_dense(diff_dense), .diff_cost(diff_cost),
    .use_cost(use_cost), .start_new_layer(start_new_layer),
    .diff_z_to_z(diff_z_to_z), .out_valid(out_valid), .row_idx(row_idx),
    .layer_done(layer_done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, ld_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_d   [0:DEPTH-1][0:S-1];
  bit            exp_v   [0:DEPTH-1][0:S-1];
  bit            exp_ld  [0:DEPTH-1];
  bit            sset    [0:DEPTH-1];
  bit            sclr    [0:DEPTH-1];
  logic [CW-1:0] exp_row [0:DEPTH-1];
  int            act_m   [S];
  int            cnt_m = 0;
  bit            sat_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  function automatic int lane_of(input logic [DW*S-1:0] v, input int c);
    logic signed [DW-1:0] x;
    x = v[DW*(S-c)-1 -: DW];
    return int'(x);
  endfunction

  // Q-format multiply: exact product, round half up, floor shift, clamp to DW bits
  function automatic int fm(input int a, input int b, output bit clamped);
    longint p, hi, lo;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -(longint'(1) <<< (DW-1));
    p = longint'(a) * longint'(b);
    p = (p + (longint'(1) <<< (FB-1))) >>> FB;
    clamped = 1'b0;
    if (p > hi) begin p = hi; clamped = 1'b1; end
    else if (p < lo) begin p = lo; clamped = 1'b1; end
    return int'(p);
  endfunction

  function automatic logic [15:0] fm16(input int a, input int b);
    bit s;
    int r;
    r = fm(a, b, s);
    return r[15:0];
  endfunction

  task automatic clear_from(input int k);
    for (int i = k; i < k + 16; i++) begin
      exp_ld[i] = 0; sset[i] = 0; sclr[i] = 0; exp_row[i] = '0;
      for (int c = 0; c < S; c++) begin exp_v[i][c] = 0; exp_d[i][c] = '0; end
    end
    cnt_m = 0;
    for (int c = 0; c < S; c++) act_m[c] = 0;
  endtask

  task automatic issue(input bit v, input bit sa, input bit snl, input bit uc,
                       input logic [DW*S-1:0] act, input logic [DW*S-1:0] dense,
                       input logic [DW*S-1:0] cost);
    int idx, p, r;
    bit s1, s2;
    in_valid = v; set_diff_act = sa; start_new_layer = snl; use_cost = uc;
    diff_act = act; diff_dense = dense; diff_cost = cost;
    idx = snl ? 0 : cnt_m;
    exp_row[cyc] = idx[CW-1:0];
    if (sa) for (int c = 0; c < S; c++) act_m[c] = lane_of(act, c);
    if (v) begin
      for (int c = 0; c < S; c++) begin
        p = fm(act_m[c], lane_of(dense, c), s1);
        if (s1) sset[cyc+1] = 1;
        r = p;
        if (uc) begin
          r = fm(p, lane_of(cost, c), s2);
          if (s2) sset[cyc+2] = 1;
        end
        exp_d[cyc+2+c][c] = r[DW-1:0];
        exp_v[cyc+2+c][c] = 1;
      end
      if (idx == NR-1) exp_ld[cyc+2+S-1] = 1;
      cnt_m = (idx == NR-1) ? 0 : idx + 1;
    end else if (snl) begin
      cnt_m = 0;
    end
    if (snl) sclr[cyc+1] = 1;
    @(posedge clk); #1;
    in_valid = 0; set_diff_act = 0; start_new_layer = 0; use_cost = 0;
    exp_row[cyc] = cnt_m[CW-1:0];
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) idle();
  endtask

  always @(negedge clk) begin
    if (!rst_n) sat_exp = 1'b0;
    else        sat_exp = (sat_exp && !sclr[cyc]) || sset[cyc];
    for (int c = 0; c < S; c++) begin
      chk("out_valid", out_valid[c], exp_v[cyc][c]);
      chk("lane_data", diff_z_to_z[DW*(S-c)-1 -: DW], exp_v[cyc][c] ? exp_d[cyc][c] : 16'h0);
    end
    chk("layer_done", layer_done, exp_ld[cyc]);
    chk("row_idx", row_idx, exp_row[cyc]);
    chk("sat_flag", sat_flag, sat_exp);
    if (layer_done) ld_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    for (int i = 0; i < DEPTH; i++) begin
      exp_ld[i] = 0; sset[i] = 0; sclr[i] = 0; exp_row[i] = '0;
      for (int c = 0; c < S; c++) begin exp_v[i][c] = 0; exp_d[i][c] = '0; end
    end
    for (int c = 0; c < S; c++) act_m[c] = 0;
    rst_n = 0; in_valid = 0; set_diff_act = 0; use_cost = 0; start_new_layer = 0;
    diff_act = '0; diff_dense = '0; diff_cost = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", diff_z_to_z, 32'h0);
    chk("reset_valid", out_valid, 32'h0);
    chk("reset_sat", sat_flag, 32'h0);
    chk("reset_done", layer_done, 32'h0);
    rst_n = 1;

    chk("model_mul", fm16(16'sh0200, 16'sh0180), 16'h0300);
    chk("model_neg", fm16(-256, 512), 16'hFE00);
    chk("model_round_up", fm16(1, 128), 16'h0001);
    chk("model_round_dn", fm16(1, 127), 16'h0000);
    chk("model_sat_hi", fm16(32512, 512), 16'h7FFF);
    chk("model_sat_lo", fm16(-32768, 512), 16'h8000);

    // basic skewed product
    issue(0, 1, 0, 0, {16'h0200, 16'h0180, 16'hFF00}, '0, '0);
    t = cyc;
    issue(1, 0, 0, 0, '0, {16'h0180, 16'h0200, 16'h0200}, '0);
    goto_cyc(t+2);
    chk("t1_lane0", diff_z_to_z[47:32], 16'h0300);
    chk("t1_vld0", out_valid, 3'b001);
    goto_cyc(t+3);
    chk("t1_lane1", diff_z_to_z[31:16], 16'h0300);
    chk("t1_vld1", out_valid, 3'b010);
    goto_cyc(t+4);
    chk("t1_lane2", diff_z_to_z[15:0], 16'hFE00);
    chk("t1_vld2", out_valid, 3'b100);

    // rounding
    t = cyc;
    issue(1, 1, 1, 0, {16'h0001, 16'h0001, 16'h0001}, {16'h0080, 16'h007F, 16'h0080}, '0);
    goto_cyc(t+2);
    chk("rnd_up", diff_z_to_z[47:32], 16'h0001);
    goto_cyc(t+3);
    chk("rnd_dn", diff_z_to_z[31:16], 16'h0000);
    chk("rnd_dn_vld", out_valid, 3'b010);
    goto_cyc(t+4);
    chk("rnd_lane2", diff_z_to_z[15:0], 16'h0001);
    chk("rnd_nosat", sat_flag, 1'b0);

    // saturation, clear, same-cycle clear vs saturate
    t = cyc;
    issue(1, 1, 0, 0, {16'h7F00, 16'h8000, 16'h0100}, {16'h0200, 16'h0200, 16'h0200}, '0);
    chk("sat_set", sat_flag, 1'b1);
    goto_cyc(t+2);
    chk("sat_hi", diff_z_to_z[47:32], 16'h7FFF);
    goto_cyc(t+3);
    chk("sat_lo", diff_z_to_z[31:16], 16'h8000);
    goto_cyc(t+4);
    chk("sat_lane2", diff_z_to_z[15:0], 16'h0200);
    issue(0, 0, 1, 0, '0, '0, '0);
    chk("sat_clear", sat_flag, 1'b0);
    issue(1, 0, 1, 0, '0, {16'h0200, 16'h0200, 16'h0200}, '0);
    chk("sat_wins", sat_flag, 1'b1);
    issue(0, 0, 1, 0, '0, '0, '0);
    t = cyc;
    goto_cyc(t+4);

    // cost mode then back-to-back plain row
    t = cyc;
    issue(1, 1, 1, 1, {16'h0200, 16'h0200, 16'h0200}, {16'h0200, 16'h0200, 16'h0200},
          {16'h0080, 16'h0080, 16'h0080});
    issue(1, 0, 0, 0, '0, {16'h0200, 16'h0200, 16'h0200}, '0);
    goto_cyc(t+2);
    chk("cost_l0", diff_z_to_z[47:32], 16'h0200);
    goto_cyc(t+3);
    chk("plain_l0", diff_z_to_z[47:32], 16'h0400);
    chk("cost_l1", diff_z_to_z[31:16], 16'h0200);
    chk("cost_vld3", out_valid, 3'b011);
    goto_cyc(t+4);
    chk("plain_l1", diff_z_to_z[31:16], 16'h0400);
    chk("cost_l2", diff_z_to_z[15:0], 16'h0200);
    chk("cost_vld4", out_valid, 3'b110);
    goto_cyc(t+5);
    chk("plain_l2", diff_z_to_z[15:0], 16'h0400);
    chk("cost_vld5", out_valid, 3'b100);

    // row counting and layer_done
    issue(1, 0, 1, 0, '0, {16'h0100, 16'h0080, 16'hFF00}, '0);
    issue(1, 0, 0, 0, '0, {16'h0300, 16'h0100, 16'h0040}, '0);
    t2 = cyc;
    issue(1, 0, 0, 0, '0, {16'h0100, 16'h0100, 16'h0300}, '0);
    issue(1, 0, 0, 0, '0, {16'h0100, 16'h0100, 16'h0100}, '0);
    chk("row_wrap", row_idx, 2'd1);
    goto_cyc(t2+4);
    chk("layer_done_on", layer_done, 1'b1);
    chk("row2_lane2", diff_z_to_z[15:0], 16'h0600);
    goto_cyc(t2+5);
    chk("layer_done_off", layer_done, 1'b0);
    chk("layer_done_count", ld_cnt, 1);

    // activation bypass, then asynchronous reset mid-stream
    t = cyc;
    issue(1, 1, 0, 0, {16'h0100, 16'h0300, 16'hFF80}, {16'h0100, 16'h0100, 16'h0100}, '0);
    idle();
    chk("bypass_l0", diff_z_to_z[47:32], 16'h0100);
    chk("bypass_vld", out_valid, 3'b001);
    issue(1, 0, 0, 0, '0, {16'h7F00, 16'h7F00, 16'h0100}, '0);
    issue(1, 0, 0, 0, '0, {16'h0200, 16'h0100, 16'h0100}, '0);
    chk("pre_rst_sat", sat_flag, 1'b1);
    #1 rst_n = 0;
    #1;
    chk("rst_data", diff_z_to_z == '0, 1'b1);
    chk("rst_valid", out_valid, 3'b000);
    chk("rst_sat", sat_flag, 1'b0);
    chk("rst_done", layer_done, 1'b0);
    clear_from(cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    t = cyc;
    issue(1, 0, 0, 0, '0, {16'h0100, 16'h0100, 16'h0100}, '0);
    goto_cyc(t+2);
    chk("post_rst_vld", out_valid, 3'b001);
    chk("post_rst_l0", diff_z_to_z[47:32], 16'h0000);
    goto_cyc(t+6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
